// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - opcode constants (5-bit encoding, 0 is never a valid op)
//   - FSM state encoding for alu_mc
//   - is_branch() helper used to qualify the registered branch decision
package alu_pkg;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_ADD   = 5'd1;
  localparam opcode_t OP_SUB   = 5'd2;
  localparam opcode_t OP_AND   = 5'd3;
  localparam opcode_t OP_OR    = 5'd4;
  localparam opcode_t OP_XOR   = 5'd5;
  localparam opcode_t OP_SL    = 5'd6;
  localparam opcode_t OP_SR    = 5'd7;
  localparam opcode_t OP_ADDI  = 5'd8;
  localparam opcode_t OP_ANDI  = 5'd9;
  localparam opcode_t OP_ORI   = 5'd10;
  localparam opcode_t OP_XORI  = 5'd11;
  localparam opcode_t OP_SLI   = 5'd12;
  localparam opcode_t OP_SRI   = 5'd13;
  localparam opcode_t OP_LOAD  = 5'd14;
  localparam opcode_t OP_STORE = 5'd15;
  localparam opcode_t OP_BEQ   = 5'd16;
  localparam opcode_t OP_BGT   = 5'd17;
  localparam opcode_t OP_BGE   = 5'd18;
  localparam opcode_t OP_BLT   = 5'd19;
  localparam opcode_t OP_JALR  = 5'd20;
  localparam opcode_t OP_MUL   = 5'd21;
  localparam opcode_t OP_SRA   = 5'd22;
  localparam opcode_t OP_BGTU  = 5'd23;
  localparam opcode_t OP_BLTU  = 5'd24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_branch(input opcode_t op);
    logic br;
    case (op)
      OP_BEQ, OP_BGT, OP_BGE, OP_BLT, OP_BGTU, OP_BLTU: br = 1'b1;
      default:                                          br = 1'b0;
    endcase
    return br;
  endfunction

endpackage

// File: rtl/alu_mc_mul.sv
// alu_mul_iter: iterative shift-add multiplier, low WIDTH bits of a*b.
// The first partial product is folded into the load cycle, so the
// product is complete WIDTH-1 clocks after the start edge (WIDTH
// partial products in total) and done stays high until the next start.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operands (one-cycle pulse at acceptance)
//   a, b        multiplicand / multiplier, sampled on start
//   done        product holds the finished result
//   product     low WIDTH bits of a*b
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;

  // Operand load with first partial product, then one partial product per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= a << 1;
      mplier_q <= b >> 1;
      acc_q    <= b[0] ? a : '0;
      cnt_q    <= CW'(1);
    end else if (cnt_q != CW'(WIDTH)) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      cnt_q    <= cnt_q + CW'(1);
    end else begin
      mcand_q  <= mcand_q;
      mplier_q <= mplier_q;
      acc_q    <= acc_q;
      cnt_q    <= cnt_q;
    end
  end

  assign done    = (cnt_q == CW'(WIDTH));
  assign product = acc_q;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with valid/ready on both sides.
// Single-cycle ops complete the cycle after acceptance; MUL (when the
// ALU_MUL_EN macro is defined) spends WIDTH busy cycles in the iterative
// multiplier. Without ALU_MUL_EN, MUL decodes as illegal and busy is 0.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (op, a, b sampled on acceptance)
//   out_valid/out_ready result handshake; outputs held while not taken
//   result, branch_taken, zero, illegal  registered results
//   busy                multiply in progress
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 5,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             branch_q, branch_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  opcode_t          op_lo_s;
  logic             op_hi_ok_s;
  logic [SHW-1:0]   shamt_s;
  logic             shift_ovf_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ill_s;
  logic             cmp_s;
  logic             alu_br_s;
  logic             accept_s;
  logic             go_mul_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_product_s;

  // Opcode bits above the 5-bit encoding must be zero for a legal op.
  assign op_lo_s     = op[4:0];
  assign op_hi_ok_s  = ((op >> 5) == '0);
  assign shamt_s     = b[SHW-1:0];
  assign shift_ovf_s = (b >= WIDTH'(WIDTH));
  assign sum_s       = a + b;

  // Single-cycle datapath: result, compare outcome and illegal decode.
  always_comb begin
    alu_res_s = '0;
    alu_ill_s = 1'b0;
    cmp_s     = 1'b0;
    if (!op_hi_ok_s) begin
      alu_ill_s = 1'b1;
    end else begin
      case (op_lo_s)
        OP_ADD, OP_ADDI, OP_LOAD, OP_STORE: alu_res_s = sum_s;
        OP_SUB:           alu_res_s = a - b;
        OP_AND, OP_ANDI:  alu_res_s = a & b;
        OP_OR,  OP_ORI:   alu_res_s = a | b;
        OP_XOR, OP_XORI:  alu_res_s = a ^ b;
        OP_SL,  OP_SLI:   alu_res_s = shift_ovf_s ? '0 : (a << shamt_s);
        OP_SR,  OP_SRI:   alu_res_s = shift_ovf_s ? '0 : (a >> shamt_s);
        OP_SRA:           alu_res_s = shift_ovf_s ? {WIDTH{a[WIDTH-1]}}
                                                  : $unsigned($signed(a) >>> shamt_s);
        OP_JALR:          alu_res_s = {sum_s[WIDTH-1:1], 1'b0};
        OP_BEQ:           cmp_s = (a == b);
        OP_BGT:           cmp_s = ($signed(a) >  $signed(b));
        OP_BGE:           cmp_s = ($signed(a) >= $signed(b));
        OP_BLT:           cmp_s = ($signed(a) <  $signed(b));
        OP_BGTU:          cmp_s = (a > b);
        OP_BLTU:          cmp_s = (a < b);
`ifdef ALU_MUL_EN
        OP_MUL:           alu_res_s = '0;
`endif
        default:          alu_ill_s = 1'b1;
      endcase
    end
  end

  assign alu_br_s = op_hi_ok_s & is_branch(op_lo_s) & cmp_s;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept_s  = in_valid & in_ready;
  assign out_valid = (state_q == DONE);

`ifdef ALU_MUL_EN
  assign go_mul_s = op_hi_ok_s & (op_lo_s == OP_MUL);
  assign busy     = (state_q == MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept_s & go_mul_s),
    .a       (a),
    .b       (b),
    .done    (mul_done_s),
    .product (mul_product_s)
  );
`else
  assign go_mul_s      = 1'b0;
  assign busy          = 1'b0;
  assign mul_done_s    = 1'b0;
  assign mul_product_s = '0;
`endif

  // Next-state and result-register load; outputs hold unless a result lands.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    branch_d  = branch_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s && go_mul_s) begin
          state_d = MUL;
        end else if (accept_s) begin
          state_d   = DONE;
          result_d  = alu_res_s;
          branch_d  = alu_br_s;
          illegal_d = alu_ill_s;
          zero_d    = (alu_res_s == '0);
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      MUL: begin
        if (mul_done_s) begin
          state_d   = DONE;
          result_d  = mul_product_s;
          branch_d  = 1'b0;
          illegal_d = 1'b0;
          zero_d    = (mul_product_s == '0);
        end else begin
          state_d = MUL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      branch_q  <= 1'b0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      branch_q  <= branch_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign result       = result_q;
  assign branch_taken = branch_q;
  assign zero         = zero_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: the driver pushes hand-computed expected
// responses at acceptance; a negedge monitor pops and compares on every
// out_valid & out_ready transfer. Works with or without ALU_MUL_EN.
module tb_alu_mc;
  import alu_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        br;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = 5'd0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        branch_taken;
  logic        zero;
  logic        illegal;
  logic        busy;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef ALU_MUL_EN
  localparam logic [15:0] MUL_RES  = 16'hFFFF;
  localparam logic        MUL_ILL  = 1'b0;
  localparam int          MUL_LAT  = 16;
  localparam int          MUL_BUSY = 16;
`else
  localparam logic [15:0] MUL_RES  = 16'h0000;
  localparam logic        MUL_ILL  = 1'b1;
  localparam int          MUL_LAT  = 0;
  localparam int          MUL_BUSY = 0;
`endif

  alu_mc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .zero         (zero),
    .illegal      (illegal),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every transferred result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {31'd0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".result"},  {16'd0, result},       {16'd0, e.res});
        chk({e.name, ".branch"},  {31'd0, branch_taken}, {31'd0, e.br});
        chk({e.name, ".illegal"}, {31'd0, illegal},      {31'd0, e.ill});
        chk({e.name, ".zero"},    {31'd0, zero},         {31'd0, (e.res == 16'h0000)});
      end
    end
  end

  // Present a request (called just after a posedge) and wait for acceptance.
  task automatic issue(input string name, input logic [4:0] o, input logic [15:0] av,
                       input logic [15:0] bv, input logic [15:0] er, input logic eb,
                       input logic ei);
    int g;
    op = o; a = av; b = bv; in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      g++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk({name, ".accept_timeout"}, {31'd0, in_ready}, 32'd1);
    end else begin
      sb.push_back('{name, er, eb, ei});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Issue one op, then measure cycles until out_valid and busy cycles seen.
  task automatic run_op(input string name, input logic [4:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] er, input logic eb,
                        input logic ei, input int exp_lat, input int exp_busy);
    int lat;
    int bsy;
    int rdy;
    @(posedge clk);
    #1;
    issue(name, o, av, bv, er, eb, ei);
    lat = 0; bsy = 0; rdy = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      lat++;
      if (busy) bsy++;
      if (in_ready) rdy++;
      @(negedge clk);
    end
    chk({name, ".latency"},   lat, exp_lat);
    chk({name, ".busy_cyc"},  bsy, exp_busy);
    chk({name, ".ready_low"}, rdy, 0);
  endtask

  initial begin
    int g;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst.out_valid", {31'd0, out_valid},    32'd0);
    chk("rst.busy",      {31'd0, busy},         32'd0);
    chk("rst.in_ready",  {31'd0, in_ready},     32'd1);
    chk("rst.result",    {16'd0, result},       32'd0);
    chk("rst.zero",      {31'd0, zero},         32'd1);
    chk("rst.illegal",   {31'd0, illegal},      32'd0);
    chk("rst.branch",    {31'd0, branch_taken}, 32'd0);

    // Reset during the 5th busy cycle of a multiply abandons it.
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    issue("mul_abort", OP_MUL, 16'h00FF, 16'h0101, MUL_RES, 1'b0, MUL_ILL);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    chk("abort.out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort.busy",      {31'd0, busy},      32'd0);
    chk("abort.in_ready",  {31'd0, in_ready},  32'd1);
    chk("abort.zero",      {31'd0, zero},      32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // Main functions and boundaries: single-cycle ops complete at N+1.
    run_op("add_1_1",    OP_ADD,  16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 0, 0);
    run_op("add_ovf",    OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 0, 0);
    run_op("add_wrap",   OP_ADDI, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1'b0, 0, 0);
    run_op("sub_zero",   OP_SUB,  16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 0, 0);
    run_op("sub_neg",    OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 0, 0);
    run_op("andi",       OP_ANDI, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 0, 0);
    run_op("blt_s",      OP_BLT,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 0, 0);
    run_op("bltu",       OP_BLTU, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 0, 0);
    run_op("bgtu",       OP_BGTU, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 0, 0);
    run_op("bgt_s",      OP_BGT,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 0, 0);
    run_op("bge_eq",     OP_BGE,  16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b0, 0, 0);
    run_op("beq_ne",     OP_BEQ,  16'h0003, 16'h0004, 16'h0000, 1'b0, 1'b0, 0, 0);
    run_op("sl_15",      OP_SL,   16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 0, 0);
    run_op("sl_16",      OP_SLI,  16'h0001, 16'h0010, 16'h0000, 1'b0, 1'b0, 0, 0);
    run_op("sr_4",       OP_SR,   16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0, 0, 0);
    run_op("sra_15",     OP_SRA,  16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0, 0, 0);
    run_op("sra_4",      OP_SRA,  16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0, 0, 0);
    run_op("sra_big",    OP_SRA,  16'h4000, 16'h0014, 16'h0000, 1'b0, 1'b0, 0, 0);
    run_op("jalr",       OP_JALR, 16'h1001, 16'h0002, 16'h1002, 1'b0, 1'b0, 0, 0);
    run_op("illegal_0",  5'd0,    16'h1234, 16'h1111, 16'h0000, 1'b0, 1'b1, 0, 0);
    run_op("illegal_25", 5'd25,   16'h1234, 16'h1111, 16'h0000, 1'b0, 1'b1, 0, 0);
    run_op("mul",        OP_MUL,  16'h00FF, 16'h0101, MUL_RES,  1'b0, MUL_ILL, MUL_LAT, MUL_BUSY);
    run_op("mul_small",  OP_MUL,  16'h0003, 16'h0007, (MUL_ILL ? 16'h0000 : 16'h0015),
           1'b0, MUL_ILL, MUL_LAT, MUL_BUSY);

    // Backpressure: result held for 4 cycles, then back-to-back accept.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue("bp_hold", OP_OR, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp.result",    {16'd0, result},    32'h0000_1235);
      chk("bp.in_ready",  {31'd0, in_ready},  32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue("b2b_xor", OP_XOR, 16'hF0F0, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b.out_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b.result",    {16'd0, result},    32'h0000_0F0F);

    // Drain the scoreboard.
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      g++;
      @(negedge clk);
    end
    chk("scoreboard_drain", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
